wifi_frame_parser: RTL and testbench



---
 rtl/wifi_frame_parser_if.sv | 33 +++
 rtl/wifi_frame_parser.sv | 168 ++++++++++++++++
 tb/tb_wifi_frame_parser.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wifi_frame_parser_if.sv
// -----------------------------------------------------------------------------
// wifi_frame_parser_if
//   Byte-in / command-out bundle for the WiFi link frame parser.
//   master : byte source (UART receiver side) plus command consumer.
//   slave  : the parser itself.
// Signals
//   pi_data   [7:0]  received byte, valid when pi_flag=1
//   pi_flag          single-cycle byte strobe
//   cmd_code  [7:0]  command byte of last valid frame
//   cmd_data  [31:0] payload, byte i at [8i+7:8i], unused bytes 0
//   cmd_len   [2:0]  payload length of last valid frame
//   cmd_valid        1-cycle pulse, new cmd_* values valid
//   frame_err        1-cycle pulse, frame dropped
// -----------------------------------------------------------------------------
interface wifi_frame_parser_if;
   logic [7:0]  pi_data;
   logic        pi_flag;
   logic [7:0]  cmd_code;
   logic [31:0] cmd_data;
   logic [2:0]  cmd_len;
   logic        cmd_valid;
   logic        frame_err;

   modport master (
      output pi_data, pi_flag,
      input  cmd_code, cmd_data, cmd_len, cmd_valid, frame_err
   );

   modport slave (
      input  pi_data, pi_flag,
      output cmd_code, cmd_data, cmd_len, cmd_valid, frame_err
   );
endinterface

// File: rtl/wifi_frame_parser.sv
// -----------------------------------------------------------------------------
// wifi_frame_parser
//   Decodes frames HDR | CMD | LEN | PAYLOAD[LEN] | SUM from a strobed byte
//   stream and emits one validated command per frame. SUM is the 8-bit
//   wraparound sum of CMD, LEN and all payload bytes.
// Ports
//   sys_clk    system clock
//   sys_rst_n  asynchronous reset, active low
//   bus        wifi_frame_parser_if.slave (pi_data/pi_flag in, cmd_* out)
// Parameters
//   HEADER      frame start byte
//   MAX_LEN     largest payload accepted (1..4)
//   TIMEOUT_CYC inter-byte timeout in sys_clk cycles
// Build option
//   FRAME_TIMEOUT_EN : when defined, a partial frame is dropped with frame_err
//   after TIMEOUT_CYC cycles without a byte; otherwise it waits indefinitely.
// -----------------------------------------------------------------------------
module wifi_frame_parser #(
   parameter logic [7:0] HEADER      = 8'hA5,
   parameter int         MAX_LEN     = 4,
   parameter int         TIMEOUT_CYC = 50_000
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   wifi_frame_parser_if.slave bus
);

   if (MAX_LEN < 1 || MAX_LEN > 4 || TIMEOUT_CYC < 2 || TIMEOUT_CYC > 131072) begin : g_param_check
      $error("wifi_frame_parser: parameter out of range");
   end

   typedef enum logic [2:0] {IDLE, CMD, LEN, DATA, SUM} state_t;

   state_t      state, state_nxt;
   logic [7:0]  cmd_r, cmd_nxt;
   logic [7:0]  sum_r, sum_nxt;
   logic [2:0]  len_r, len_nxt;
   logic [1:0]  idx_r, idx_nxt;
   logic [31:0] pay_r, pay_nxt;
   logic [7:0]  code_r, code_nxt;
   logic [2:0]  olen_r, olen_nxt;
   logic [31:0] data_r, data_nxt;
   logic        valid_r, valid_nxt;
   logic        err_r, err_nxt;
   logic        timeout;

`ifdef FRAME_TIMEOUT_EN
   logic [16:0] idle_cnt;

   // A strobe in the expiry cycle takes priority over the timeout.
   assign timeout = (state != IDLE) && !bus.pi_flag &&
                    (idle_cnt == 17'(TIMEOUT_CYC - 1));

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)
         idle_cnt <= '0;
      else if (state == IDLE || bus.pi_flag || timeout)
         idle_cnt <= '0;
      else
         idle_cnt <= idle_cnt + 17'd1;
   end
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      cmd_nxt   = cmd_r;
      sum_nxt   = sum_r;
      len_nxt   = len_r;
      idx_nxt   = idx_r;
      pay_nxt   = pay_r;
      code_nxt  = code_r;
      olen_nxt  = olen_r;
      data_nxt  = data_r;
      valid_nxt = 1'b0;
      err_nxt   = 1'b0;

      if (timeout) begin
         err_nxt   = 1'b1;
         state_nxt = IDLE;
      end else if (bus.pi_flag) begin
         case (state)
            IDLE: begin
               // Non-header bytes between frames are silently dropped.
               if (bus.pi_data == HEADER) begin
                  state_nxt = CMD;
                  sum_nxt   = '0;
                  pay_nxt   = '0;
                  idx_nxt   = '0;
               end
            end
            CMD: begin
               cmd_nxt   = bus.pi_data;
               sum_nxt   = bus.pi_data;
               state_nxt = LEN;
            end
            LEN: begin
               len_nxt = bus.pi_data[2:0];
               sum_nxt = sum_r + bus.pi_data;
               if (bus.pi_data > 8'(MAX_LEN)) begin
                  err_nxt   = 1'b1;
                  state_nxt = IDLE;
               end else if (bus.pi_data == 8'd0) begin
                  state_nxt = SUM;
               end else begin
                  state_nxt = DATA;
               end
            end
            DATA: begin
               pay_nxt[{idx_r, 3'b000} +: 8] = bus.pi_data;
               sum_nxt = sum_r + bus.pi_data;
               idx_nxt = idx_r + 2'd1;
               if ({1'b0, idx_r} == len_r - 3'd1)
                  state_nxt = SUM;
            end
            SUM: begin
               // Output registers only move on a good checksum.
               if (bus.pi_data == sum_r) begin
                  valid_nxt = 1'b1;
                  code_nxt  = cmd_r;
                  olen_nxt  = len_r;
                  data_nxt  = pay_r;
               end else begin
                  err_nxt = 1'b1;
               end
               state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state   <= IDLE;
         cmd_r   <= '0;
         sum_r   <= '0;
         len_r   <= '0;
         idx_r   <= '0;
         pay_r   <= '0;
         code_r  <= '0;
         olen_r  <= '0;
         data_r  <= '0;
         valid_r <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         state   <= state_nxt;
         cmd_r   <= cmd_nxt;
         sum_r   <= sum_nxt;
         len_r   <= len_nxt;
         idx_r   <= idx_nxt;
         pay_r   <= pay_nxt;
         code_r  <= code_nxt;
         olen_r  <= olen_nxt;
         data_r  <= data_nxt;
         valid_r <= valid_nxt;
         err_r   <= err_nxt;
      end
   end

   assign bus.cmd_code  = code_r;
   assign bus.cmd_len   = olen_r;
   assign bus.cmd_data  = data_r;
   assign bus.cmd_valid = valid_r;
   assign bus.frame_err = err_r;

endmodule

// File: tb/tb_wifi_frame_parser.sv
// -----------------------------------------------------------------------------
// tb_wifi_frame_parser
//   Directed frames with hand-derived expectations plus randomized frame
//   streams checked against a queue-based frame model.
// -----------------------------------------------------------------------------
module tb_wifi_frame_parser;
   localparam int TO_CYC = 100;

   logic sys_clk = 1'b0;
   logic sys_rst_n;

   wifi_frame_parser_if bus();

   wifi_frame_parser #(
      .HEADER      (8'hA5),
      .MAX_LEN     (4),
      .TIMEOUT_CYC (TO_CYC)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .bus       (bus)
   );

   always #5 sys_clk = ~sys_clk;

   int total = 0;
   int bad   = 0;

   // observations from the byte driver
   logic [44:0] obs_bus;
   int          stray;
   int          n_valid, n_err, last_idx;
   logic [7:0]  fb [8];

   // frame model state
   logic [7:0]  fq [$];
   logic [7:0]  stream_q [$];
   int          exp_ev;
   logic [7:0]  exp_code;
   logic [2:0]  exp_len;
   logic [31:0] exp_data;

   function automatic void model_reset();
      fq.delete();
      exp_ev   = 0;
      exp_code = '0;
      exp_len  = '0;
      exp_data = '0;
   endfunction

   // Collects a frame as a list of bytes; decides once the list is complete.
   function automatic void model_push(input logic [7:0] b);
      int n;
      logic [7:0] s;
      exp_ev = 0;
      if (fq.size() == 0) begin
         if (b == 8'hA5) fq.push_back(b);
         return;
      end
      fq.push_back(b);
      n = fq.size();
      if (n == 3 && b > 8'd4) begin
         exp_ev = 2;
         fq.delete();
      end else if (n >= 3 && n == 4 + int'(fq[2])) begin
         s = 8'd0;
         for (int i = 1; i < n - 1; i++) s = s + fq[i];
         if (s == b) begin
            exp_ev   = 1;
            exp_code = fq[1];
            exp_len  = fq[2][2:0];
            exp_data = '0;
            for (int i = 0; i < int'(fq[2]); i++) exp_data[8*i +: 8] = fq[3+i];
         end else begin
            exp_ev = 2;
         end
         fq.delete();
      end
   endfunction

   task automatic send_byte(input logic [7:0] b, input int gap);
      @(negedge sys_clk);
      bus.pi_data = b;
      bus.pi_flag = 1'b1;
      @(negedge sys_clk);
      bus.pi_flag = 1'b0;
      obs_bus = {bus.cmd_valid, bus.frame_err, bus.cmd_code, bus.cmd_len, bus.cmd_data};
      for (int i = 0; i < gap; i++) begin
         @(negedge sys_clk);
         if (bus.cmd_valid || bus.frame_err) stray++;
      end
   endtask

   task automatic feed(input logic [7:0] bytes [8], input int n, input int gap);
      n_valid  = 0;
      n_err    = 0;
      last_idx = -1;
      stray    = 0;
      for (int i = 0; i < n; i++) begin
         send_byte(bytes[i], gap);
         model_push(bytes[i]);
         if (obs_bus[44]) begin n_valid++; last_idx = i; end
         if (obs_bus[43]) begin n_err++;   last_idx = i; end
      end
   endtask

   task automatic gen_frame();
      int kind, len;
      logic [7:0] s, c, b;
      kind = $urandom_range(0, 9);
      if (kind == 8) begin
         repeat ($urandom_range(1, 3)) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hA5) b = 8'h5A;
            stream_q.push_back(b);
         end
         return;
      end
      stream_q.push_back(8'hA5);
      c = 8'($urandom);
      stream_q.push_back(c);
      if (kind == 7) begin
         stream_q.push_back(8'($urandom_range(5, 255)));
         return;
      end
      len = $urandom_range(0, 4);
      stream_q.push_back(8'(len));
      s = c + 8'(len);
      for (int i = 0; i < len; i++) begin
         b = (kind == 9) ? 8'hA5 : 8'($urandom);
         stream_q.push_back(b);
         s = s + b;
      end
      stream_q.push_back(kind == 6 ? s + 8'($urandom_range(1, 255)) : s);
   endtask

   task automatic test_reset();
      sys_rst_n   = 1'b0;
      bus.pi_flag = 1'b0;
      bus.pi_data = 8'h00;
      model_reset();
      repeat (3) @(negedge sys_clk);
      total++;
      if ({bus.cmd_valid, bus.frame_err, bus.cmd_code, bus.cmd_len, bus.cmd_data} !== 45'd0)
         $display("FAIL reset_outputs got=%h want=0",
                  {bus.cmd_valid, bus.frame_err, bus.cmd_code, bus.cmd_len, bus.cmd_data});
      if ({bus.cmd_valid, bus.frame_err, bus.cmd_code, bus.cmd_len, bus.cmd_data} !== 45'd0) bad++;
      sys_rst_n = 1'b1;
      @(negedge sys_clk);
   endtask

   task automatic test_valid_frame();
      fb = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h45, 8'h00, 8'h00};
      feed(fb, 6, 1);
      total++;
      if ({n_valid, n_err, last_idx, stray} !== {32'd1, 32'd0, 32'd5, 32'd0}) begin
         bad++;
         $display("FAIL t1_events valid=%0d err=%0d last=%0d stray=%0d want 1/0/5/0", n_valid, n_err, last_idx, stray);
      end
      total++;
      if ({bus.cmd_code, bus.cmd_len, bus.cmd_data} !== {8'h10, 3'd2, 32'h0000_2211}) begin
         bad++;
         $display("FAIL t1_fields got=%h/%0d/%h want 10/2/00002211", bus.cmd_code, bus.cmd_len, bus.cmd_data);
      end
   endtask

   task automatic test_bad_checksum();
      fb = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h46, 8'h00, 8'h00};
      feed(fb, 6, 2);
      total++;
      if ({n_valid, n_err, last_idx, stray} !== {32'd0, 32'd1, 32'd5, 32'd0}) begin
         bad++;
         $display("FAIL t3_events valid=%0d err=%0d last=%0d stray=%0d want 0/1/5/0", n_valid, n_err, last_idx, stray);
      end
      total++;
      if ({bus.cmd_code, bus.cmd_len, bus.cmd_data} !== {8'h10, 3'd2, 32'h0000_2211}) begin
         bad++;
         $display("FAIL t3_hold got=%h/%0d/%h want 10/2/00002211", bus.cmd_code, bus.cmd_len, bus.cmd_data);
      end
   endtask

   task automatic test_zero_len();
      // trailing 33 44 arrive in IDLE and must be ignored
      fb = '{8'hA5, 8'h20, 8'h00, 8'h20, 8'h33, 8'h44, 8'h00, 8'h00};
      feed(fb, 6, 1);
      total++;
      if ({n_valid, n_err, last_idx, stray} !== {32'd1, 32'd0, 32'd3, 32'd0}) begin
         bad++;
         $display("FAIL t2_events valid=%0d err=%0d last=%0d stray=%0d want 1/0/3/0", n_valid, n_err, last_idx, stray);
      end
      total++;
      if ({bus.cmd_code, bus.cmd_len, bus.cmd_data} !== {8'h20, 3'd0, 32'h0}) begin
         bad++;
         $display("FAIL t2_fields got=%h/%0d/%h want 20/0/00000000", bus.cmd_code, bus.cmd_len, bus.cmd_data);
      end
   endtask

   task automatic test_length_bounds();
      fb = '{8'hA5, 8'h10, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      feed(fb, 3, 1);
      total++;
      if ({n_valid, n_err, last_idx, stray} !== {32'd0, 32'd1, 32'd2, 32'd0}) begin
         bad++;
         $display("FAIL t4_badlen valid=%0d err=%0d last=%0d stray=%0d want 0/1/2/0", n_valid, n_err, last_idx, stray);
      end
      fb = '{8'hA5, 8'h01, 8'h01, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h00};
      feed(fb, 5, 1);
      total++;
      if ({n_valid, n_err, last_idx, {bus.cmd_code, bus.cmd_len, bus.cmd_data}} !==
          {32'd1, 32'd0, 32'd4, {8'h01, 3'd1, 32'h0000_00FF}}) begin
         bad++;
         $display("FAIL t4_next valid=%0d err=%0d last=%0d fields=%h/%0d/%h want 1/0/4 01/1/000000FF",
                  n_valid, n_err, last_idx, bus.cmd_code, bus.cmd_len, bus.cmd_data);
      end
      // longest accepted payload: 77+04+01+02+03+04 = 85
      fb = '{8'hA5, 8'h77, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h85};
      feed(fb, 8, 1);
      total++;
      if ({n_valid, n_err, last_idx, {bus.cmd_code, bus.cmd_len, bus.cmd_data}} !==
          {32'd1, 32'd0, 32'd7, {8'h77, 3'd4, 32'h0403_0201}}) begin
         bad++;
         $display("FAIL maxlen valid=%0d err=%0d last=%0d fields=%h/%0d/%h want 1/0/7 77/4/04030201",
                  n_valid, n_err, last_idx, bus.cmd_code, bus.cmd_len, bus.cmd_data);
      end
   endtask

   task automatic test_reset_mid_frame();
      int pulses;
      fb = '{8'hA5, 8'h30, 8'h02, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00};
      feed(fb, 4, 1);
      #2 sys_rst_n = 1'b0;
      pulses = 0;
      repeat (3) begin
         @(negedge sys_clk);
         if ({bus.cmd_valid, bus.frame_err, bus.cmd_code, bus.cmd_len, bus.cmd_data} !== 45'd0) pulses++;
      end
      total++;
      if (pulses !== 0) begin
         bad++;
         $display("FAIL t6_in_reset nonzero_cycles=%0d want 0", pulses);
      end
      sys_rst_n = 1'b1;
      model_reset();
      // 30+01+A5 = D6; the A5 here is payload, not a new header
      fb = '{8'hA5, 8'h30, 8'h01, 8'hA5, 8'hD6, 8'h00, 8'h00, 8'h00};
      feed(fb, 5, 1);
      total++;
      if ({n_valid, n_err, last_idx, stray} !== {32'd1, 32'd0, 32'd4, 32'd0}) begin
         bad++;
         $display("FAIL t6_events valid=%0d err=%0d last=%0d stray=%0d want 1/0/4/0", n_valid, n_err, last_idx, stray);
      end
      total++;
      if ({bus.cmd_code, bus.cmd_len, bus.cmd_data} !== {8'h30, 3'd1, 32'h0000_00A5}) begin
         bad++;
         $display("FAIL t6_fields got=%h/%0d/%h want 30/1/000000A5", bus.cmd_code, bus.cmd_len, bus.cmd_data);
      end
   endtask

`ifdef FRAME_TIMEOUT_EN
   task automatic test_timeout();
      int err_at, err_cnt, other;
      fb = '{8'hA5, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      feed(fb, 2, 0);
      err_at = 0; err_cnt = 0; other = 0;
      for (int k = 1; k <= TO_CYC + 5; k++) begin
         @(negedge sys_clk);
         if (bus.frame_err) begin err_cnt++; err_at = k; end
         if (bus.cmd_valid) other++;
      end
      total++;
      if ({err_at, err_cnt, other} !== {TO_CYC, 32'd1, 32'd0}) begin
         bad++;
         $display("FAIL timeout_expiry at=%0d count=%0d valids=%0d want %0d/1/0", err_at, err_cnt, other, TO_CYC);
      end
      model_reset();
      // byte lands in the expiry cycle: frame must survive
      feed(fb, 2, 0);
      other = 0;
      repeat (TO_CYC - 2) begin
         @(negedge sys_clk);
         if (bus.cmd_valid || bus.frame_err) other++;
      end
      fb = '{8'h01, 8'h77, 8'h88, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      feed(fb, 3, 0);
      total++;
      if ({other, n_valid, n_err, last_idx, {bus.cmd_code, bus.cmd_len, bus.cmd_data}} !==
          {32'd0, 32'd1, 32'd0, 32'd2, {8'h10, 3'd1, 32'h0000_0077}}) begin
         bad++;
         $display("FAIL timeout_edge wait_pulses=%0d valid=%0d err=%0d last=%0d fields=%h/%0d/%h want 0/1/0/2 10/1/00000077",
                  other, n_valid, n_err, last_idx, bus.cmd_code, bus.cmd_len, bus.cmd_data);
      end
   endtask
`else
   task automatic test_timeout();
      int other;
      fb = '{8'hA5, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      feed(fb, 2, 0);
      other = 0;
      repeat (3 * TO_CYC) begin
         @(negedge sys_clk);
         if (bus.cmd_valid || bus.frame_err) other++;
      end
      fb = '{8'h01, 8'h77, 8'h88, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      feed(fb, 3, 1);
      total++;
      if ({other, n_valid, n_err, last_idx, {bus.cmd_code, bus.cmd_len, bus.cmd_data}} !==
          {32'd0, 32'd1, 32'd0, 32'd2, {8'h10, 3'd1, 32'h0000_0077}}) begin
         bad++;
         $display("FAIL no_timeout wait_pulses=%0d valid=%0d err=%0d last=%0d fields=%h/%0d/%h want 0/1/0/2 10/1/00000077",
                  other, n_valid, n_err, last_idx, bus.cmd_code, bus.cmd_len, bus.cmd_data);
      end
   endtask
`endif

   task automatic test_random_frames(input int nframes, input int max_gap);
      logic [7:0] b;
      logic [44:0] want;
      stream_q.delete();
      repeat (nframes) gen_frame();
      stray = 0;
      while (stream_q.size() > 0) begin
         b = stream_q.pop_front();
         send_byte(b, $urandom_range(0, max_gap));
         model_push(b);
         want = {exp_ev == 1, exp_ev == 2, exp_code, exp_len, exp_data};
         total++;
         if (obs_bus !== want) begin
            bad++;
            $display("FAIL random_byte %h got=%h want=%h (valid,err,code,len,data)", b, obs_bus, want);
         end
      end
      total++;
      if (stray !== 0) begin
         bad++;
         $display("FAIL random_stray pulses=%0d want 0", stray);
      end
   endtask

   task automatic test_back_to_back();
      test_random_frames(25, 0);
   endtask

   initial begin
      test_reset();
      test_valid_frame();
      test_bad_checksum();
      test_zero_len();
      test_length_bounds();
      test_reset_mid_frame();
      test_timeout();
      test_random_frames(40, 3);
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
